// File: rtl/alu_result_stage.sv
// alu_result_stage: registers the ALU result, tag and Z/N/C/V flags for writeback; ALU_SKID_EN selects the skid buffer.
// Latency: input accepted on edge N is presented with OutValid=1 in cycle N+1; one entry per cycle at full rate.
// Backpressure: valid/ready; InReady is combinational from OutReady, or a registered !SkidValid when ALU_SKID_EN.
module alu_result_stage #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Result,
  input  logic             CarryOut,
  input  logic             AMsb,
  input  logic             BMsb,
  input  logic [2:0]       Op,
  input  logic [TAG_W-1:0] Rd,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutResult,
  output logic [TAG_W-1:0] OutRd,
  output logic             OutZero,
  output logic             OutNeg,
  output logic             OutCarry,
  output logic             OutOvf,
  output logic [CNT_W-1:0] StallCount
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] rd;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } entry_t;

  localparam logic [2:0] OP_ADDSUB = 3'b010;

  entry_t in_ent;
  logic   is_addsub;

  // Carry and overflow only mean something for ADD/SUB; every other op, reserved included, forces them low.
  always_comb begin
    is_addsub     = (Op == OP_ADDSUB);
    in_ent.result = Result;
    in_ent.rd     = Rd;
    in_ent.zero   = (Result == '0);
    in_ent.neg    = Result[WIDTH-1];
    in_ent.carry  = is_addsub & CarryOut;
    in_ent.ovf    = is_addsub & (AMsb == BMsb) & (Result[WIDTH-1] != AMsb);
  end

  entry_t main_q, main_d;
  logic   main_vld_q, main_vld_d;
  logic   accept;
  logic   consume;

  assign accept  = InValid & InReady;
  assign consume = main_vld_q & OutReady;

`ifdef ALU_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_vld_q, skid_vld_d;
  logic   in_rdy_q;

  // When full, InReady is already low, so consume never coincides with accept while the skid slot is occupied.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || consume) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_ent;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= !skid_vld_d;
    end
  end

  assign InReady = in_rdy_q;
`else
  assign InReady = !main_vld_q || OutReady;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (accept) begin
      main_d     = in_ent;
      main_vld_d = 1'b1;
    end else if (consume) begin
      main_vld_d = 1'b0;
    end
  end
`endif

  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (main_vld_q && !OutReady && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      stall_q    <= stall_d;
    end
  end

  assign OutValid   = main_vld_q;
  assign OutResult  = main_q.result;
  assign OutRd      = main_q.rd;
  assign OutZero    = main_q.zero;
  assign OutNeg     = main_q.neg;
  assign OutCarry   = main_q.carry;
  assign OutOvf     = main_q.ovf;
  assign StallCount = stall_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle, plus directed literal checks.
module tb_alu_result_stage;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [23:0] Result;
  logic        CarryOut;
  logic        AMsb;
  logic        BMsb;
  logic [2:0]  Op;
  logic [3:0]  Rd;
  logic        OutValid;
  logic        OutReady;
  logic [23:0] OutResult;
  logic [3:0]  OutRd;
  logic        OutZero;
  logic        OutNeg;
  logic        OutCarry;
  logic        OutOvf;
  logic [15:0] StallCount;

  alu_result_stage #(.WIDTH(24), .TAG_W(4), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Result(Result), .CarryOut(CarryOut), .AMsb(AMsb), .BMsb(BMsb), .Op(Op), .Rd(Rd),
    .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult), .OutRd(OutRd),
    .OutZero(OutZero), .OutNeg(OutNeg), .OutCarry(OutCarry), .OutOvf(OutOvf),
    .StallCount(StallCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [23:0] result;
    logic [3:0]  rd;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t        mq[$];
  int          mstall = 0;
  logic [3:0]  out_log[$];
  int          out_cyc[$];
  bit          m_acc, m_con;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_entry(input logic [23:0] r, input logic [3:0] rd, input logic [2:0] op,
                                        input logic co, input logic am, input logic bm);
    exp_t e;
    bit   add;
    add      = (op == 3'd2);
    e.result = r;
    e.rd     = rd;
    e.z      = (r == 24'd0);
    e.n      = r[23];
    e.c      = add ? co : 1'b0;
    e.v      = add && (am == bm) && (r[23] != am);
    return e;
  endfunction

  function automatic bit exp_ready();
`ifdef ALU_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (OutReady == 1'b1);
`endif
  endfunction

  always @(posedge Clock) cyc <= cyc + 1;

  // Reference model: a plain FIFO of expected entries plus a saturating stall count.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mq.delete();
      mstall = 0;
    end else begin
      m_acc = (InValid == 1'b1) && exp_ready();
      m_con = (mq.size() > 0) && (OutReady == 1'b1);
      if ((mq.size() > 0) && (OutReady == 1'b0) && (mstall != 65535)) mstall++;
      if (m_con) void'(mq.pop_front());
      if (m_acc) mq.push_back(expect_entry(Result, Rd, Op, CarryOut, AMsb, BMsb));
    end
  end

  always @(negedge Clock) begin
    chk("out_valid", {63'd0, OutValid}, {63'd0, mq.size() > 0});
    chk("in_ready", {63'd0, InReady}, {63'd0, exp_ready()});
    chk("stall_count", {48'd0, StallCount}, 64'(mstall));
    if (mq.size() > 0)
      chk("out_entry", {30'd0, OutResult, OutRd, OutZero, OutNeg, OutCarry, OutOvf}, {30'd0, mq[0]});
    if (OutValid && OutReady) begin
      out_log.push_back(OutRd);
      out_cyc.push_back(cyc);
    end
  end

  task automatic set_in(input logic [23:0] r, input logic [3:0] rd, input logic [2:0] op,
                        input logic co, input logic am, input logic bm);
    Result = r; Rd = rd; Op = op; CarryOut = co; AMsb = am; BMsb = bm;
  endtask

  // Holds InValid until the stage takes the entry; returns at posedge+1 of the cycle after acceptance.
  task automatic send();
    bit rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    InValid = 1'b1;
    while (!rdy && n < 50) begin
      @(negedge Clock);
      rdy = InReady;
      @(posedge Clock);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no InReady within %0d cycles expected acceptance", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    int c0;
    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    set_in(24'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_out_valid", {63'd0, OutValid}, 64'd0);
    chk("rst_in_ready", {63'd0, InReady}, 64'd1);
    chk("rst_stall", {48'd0, StallCount}, 64'd0);
    chk("rst_out_fields", {30'd0, OutResult, OutRd, OutZero, OutNeg, OutCarry, OutOvf}, 64'd0);
    #10 Reset = 1'b1;
    @(posedge Clock); #1;

    repeat (5) begin
      @(posedge Clock); #1;
      chk("idle_out_valid", {63'd0, OutValid}, 64'd0);
      chk("idle_in_ready", {63'd0, InReady}, 64'd1);
      chk("idle_stall", {48'd0, StallCount}, 64'd0);
    end

    // ADD with signed overflow: two positive operands give a negative result.
    set_in(24'h800000, 4'd1, 3'b010, 1'b0, 1'b0, 1'b0);
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    chk("add_valid", {63'd0, OutValid}, 64'd1);
    chk("add_ovf", {63'd0, OutOvf}, 64'd1);
    chk("add_neg", {63'd0, OutNeg}, 64'd1);
    chk("add_zero", {63'd0, OutZero}, 64'd0);
    chk("add_carry", {63'd0, OutCarry}, 64'd0);
    chk("add_result", {40'd0, OutResult}, 64'h800000);

    set_in(24'h000000, 4'd2, 3'b010, 1'b1, 1'b1, 1'b0);
    InValid = 1'b1;
    @(posedge Clock); #1;
    chk("sub_zero", {63'd0, OutZero}, 64'd1);
    chk("sub_carry", {63'd0, OutCarry}, 64'd1);
    chk("sub_ovf", {63'd0, OutOvf}, 64'd0);
    set_in(24'h000000, 4'd3, 3'b100, 1'b1, 1'b1, 1'b0);
    @(posedge Clock); #1;
    chk("xor_zero", {63'd0, OutZero}, 64'd1);
    chk("xor_carry", {63'd0, OutCarry}, 64'd0);
    chk("xor_rd", {60'd0, OutRd}, 64'd3);
    set_in(24'h800000, 4'd4, 3'b110, 1'b1, 1'b0, 1'b0);
    @(posedge Clock); #1;
    InValid = 1'b0;
    chk("rsvd_carry", {63'd0, OutCarry}, 64'd0);
    chk("rsvd_ovf", {63'd0, OutOvf}, 64'd0);
    chk("rsvd_neg", {63'd0, OutNeg}, 64'd1);
    repeat (2) @(posedge Clock); #1;

    // Backpressure: tags 1..6 streamed while writeback stalls for 4 cycles.
    out_log.delete();
    nacc = 0;
    fork
      begin
        for (int t = 1; t <= 6; t++) begin
          set_in(24'h010000 * t, 4'(t), 3'b010, 1'(t % 2), 1'b0, 1'b1);
          send();
        end
        InValid = 1'b0;
      end
      begin
        OutReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge Clock);
          if (InValid && InReady) nacc++;
`ifdef ALU_SKID_EN
          if (k >= 2) chk("bp_in_ready_low", {63'd0, InReady}, 64'd0);
`endif
          @(posedge Clock);
        end
        #1;
        OutReady = 1'b1;
        chk("bp_stall_at_release", {48'd0, StallCount}, 64'd3);
`ifdef ALU_SKID_EN
        chk("bp_accepts", 64'(nacc), 64'd2);
`else
        chk("bp_accepts", 64'(nacc), 64'd1);
`endif
      end
    join
    repeat (8) @(posedge Clock); #1;
    chk("bp_count", 64'(out_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      chk("bp_order", {60'd0, out_log[i]}, 64'(i + 1));

    // Full-rate stream of 64 entries.
    out_log.delete();
    out_cyc.delete();
    OutReady = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i % 9 == 0) set_in(24'd0, 4'(i), 3'(i), b[0], b[1], b[2]);
      else set_in({b, ~b, b ^ 8'h5A}, 4'(i), 3'(i), b[0], b[1], b[2]);
      InValid = 1'b1;
      @(posedge Clock); #1;
    end
    InValid = 1'b0;
    repeat (2) @(posedge Clock); #1;
    chk("fr_count", 64'(out_log.size()), 64'd64);
    if (out_log.size() == 64) begin
      chk("fr_latency", 64'(out_cyc[0]), 64'(c0 + 1));
      chk("fr_consecutive", 64'(out_cyc[63] - out_cyc[0]), 64'd63);
      for (int i = 0; i < 64; i++) chk("fr_order", {60'd0, out_log[i]}, 64'(i % 16));
    end

    // Reset while entries are held.
    OutReady = 1'b0;
    set_in(24'h00ABCD, 4'd3, 3'b001, 1'b0, 1'b0, 1'b0);
    send();
    set_in(24'h00BEEF, 4'd4, 3'b001, 1'b0, 1'b0, 1'b0);
    @(posedge Clock); #1;
    InValid = 1'b0;
    @(posedge Clock); #3;
    Reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, OutValid}, 64'd0);
    chk("mid_rst_stall", {48'd0, StallCount}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, InReady}, 64'd1);
    #10 Reset = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b1;
    set_in(24'h123456, 4'hA, 3'b000, 1'b0, 1'b0, 1'b0);
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    chk("post_rst_valid", {63'd0, OutValid}, 64'd1);
    chk("post_rst_rd", {60'd0, OutRd}, 64'hA);
    chk("post_rst_result", {40'd0, OutResult}, 64'h123456);
    @(posedge Clock); #1;
    chk("post_rst_alone", {63'd0, OutValid}, 64'd0);

    repeat (3) @(posedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
